memory: RTL and testbench

Synchronous 32-entry x 32-bit register memory with one write port and two independent read ports. It serves as the register storage for the R-type datapath: two source operands are read and one result is written per clock. All state clears asynchronously on reset. Read outputs are registered and held between enabled reads.

---
 rtl/memory.sv | 68 ++++++
 tb/tb_memory.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/memory.sv
// memory: 32 x 32-bit register storage for the R-type datapath.
// One write port and two read ports that share a single read enable.
// Read data is registered: addresses presented before an enabled edge
// appear on rd_data1/rd_data2 after that edge and hold until the next
// enabled read edge. A write and a read at the same address on the same
// edge return the new data, so a result is usable in the cycle it is
// written. Every address, including 0, is ordinary writable storage.
// Reset (rst low) asynchronously clears the storage and both outputs.
module memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Storage array; cleared as a whole on reset.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Per-port bypass selects and next read values.
  logic                  w_byp1;
  logic                  w_byp2;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  // Storage update: clear on reset, otherwise write the addressed word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Read-during-write forwarding, evaluated independently per port. The
  // result only feeds the output registers, so no input reaches rd_data
  // combinationally, and an X address with rd_en low is never captured.
  always_comb begin
    w_byp1 = wr_en && (wr_addr == rd_addr1);
    w_byp2 = wr_en && (wr_addr == rd_addr2);
    w_rd1  = w_byp1 ? wr_data : r_mem[rd_addr1];
    w_rd2  = w_byp2 ? wr_data : r_mem[rd_addr2];
  end

  // Registered read ports: load on an enabled edge, hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
    end else if (rd_en) begin
      rd_data1 <= w_rd1;
      rd_data2 <= w_rd2;
    end
  end

endmodule

// File: tb/tb_memory.sv
// Directed bench for memory: reset, write/read-back, hold, bypass and
// asynchronous reset. Inputs change and outputs are sampled 1 ns after
// each rising edge, well away from the active edge.
module tb_memory;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic [DW-1:0] rd_data1;
  logic [DW-1:0] rd_data2;

  int checks = 0;
  int errors = 0;

  memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2)
  );

  // Clock: 10 ns period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] observed,
                       input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rd_en    = 1'b1;
    rd_addr1 = a1;
    rd_addr2 = a2;
    tick();
    rd_en    = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_en    = 1'b0;
    rd_addr1 = '0;
    rd_addr2 = '0;

    // Reset held for 10 ns, outputs already cleared.
    #10;
    check("reset_rd1", rd_data1, 32'h0);
    check("reset_rd2", rd_data2, 32'h0);
    #2;
    rst = 1'b1;
    tick();
    check("idle_rd1", rd_data1, 32'h0);
    check("idle_rd2", rd_data2, 32'h0);

    // Every location reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      do_read(AW'(i), AW'(31 - i));
      check("clr_rd1", rd_data1, 32'h0);
      check("clr_rd2", rd_data2, 32'h0);
    end

    // Write then read back on both ports.
    do_write(5'd8, 32'h0000_1122);
    do_write(5'd2, 32'h0000_3344);
    do_read(5'd8, 5'd2);
    check("wr8_rd1", rd_data1, 32'h0000_1122);
    check("wr2_rd2", rd_data2, 32'h0000_3344);

    // Unwritten location.
    do_read(5'd5, 5'd2);
    check("unwr_rd1", rd_data1, 32'h0);
    check("unwr_rd2", rd_data2, 32'h0000_3344);

    // Hold with rd_en low while addresses change and 8 is rewritten.
    rd_en    = 1'b0;
    rd_addr1 = 5'd8;
    rd_addr2 = 5'd8;
    do_write(5'd8, 32'h0000_5566);
    check("hold_rd1", rd_data1, 32'h0);
    check("hold_rd2", rd_data2, 32'h0000_3344);
    rd_addr1 = 'x;
    rd_addr2 = 'x;
    tick();
    check("holdx_rd1", rd_data1, 32'h0);
    check("holdx_rd2", rd_data2, 32'h0000_3344);
    do_read(5'd8, 5'd2);
    check("after_hold_rd1", rd_data1, 32'h0000_5566);
    check("after_hold_rd2", rd_data2, 32'h0000_3344);

    // Bypass on both ports.
    do_write(5'd4, 32'h0000_0007);
    wr_en    = 1'b1;
    wr_addr  = 5'd4;
    wr_data  = 32'hDEAD_BEEF;
    rd_en    = 1'b1;
    rd_addr1 = 5'd4;
    rd_addr2 = 5'd4;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("byp_rd1", rd_data1, 32'hDEAD_BEEF);
    check("byp_rd2", rd_data2, 32'hDEAD_BEEF);
    do_read(5'd4, 5'd4);
    check("byp_next_rd1", rd_data1, 32'hDEAD_BEEF);
    check("byp_next_rd2", rd_data2, 32'hDEAD_BEEF);

    // Bypass on port 1 only; port 2 reads stored data.
    wr_en    = 1'b1;
    wr_addr  = 5'd9;
    wr_data  = 32'hA5A5_5A5A;
    rd_en    = 1'b1;
    rd_addr1 = 5'd9;
    rd_addr2 = 5'd4;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("byp1_rd1", rd_data1, 32'hA5A5_5A5A);
    check("byp1_rd2", rd_data2, 32'hDEAD_BEEF);

    // Bypass on port 2 only.
    wr_en    = 1'b1;
    wr_addr  = 5'd17;
    wr_data  = 32'h1357_9BDF;
    rd_en    = 1'b1;
    rd_addr1 = 5'd2;
    rd_addr2 = 5'd17;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("byp2_rd1", rd_data1, 32'h0000_3344);
    check("byp2_rd2", rd_data2, 32'h1357_9BDF);

    // Address 0 and 31 are ordinary storage.
    do_write(5'd0, 32'hFFFF_0000);
    do_write(5'd31, 32'h0000_0001);
    do_read(5'd0, 5'd31);
    check("a0_rd1", rd_data1, 32'hFFFF_0000);
    check("a31_rd2", rd_data2, 32'h0000_0001);

    // Async reset between edges.
    do_write(5'd8, 32'h0000_1122);
    do_read(5'd8, 5'd9);
    check("pre_rst_rd1", rd_data1, 32'h0000_1122);
    check("pre_rst_rd2", rd_data2, 32'hA5A5_5A5A);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_rd1", rd_data1, 32'h0);
    check("async_rst_rd2", rd_data2, 32'h0);
    #2;
    rst = 1'b1;
    do_read(5'd8, 5'd9);
    check("post_rst_rd1", rd_data1, 32'h0);
    check("post_rst_rd2", rd_data2, 32'h0);

    // Write and read in flight across an edge with reset held are discarded.
    rst      = 1'b0;
    wr_en    = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 32'h0BAD_F00D;
    rd_en    = 1'b1;
    rd_addr1 = 5'd3;
    rd_addr2 = 5'd3;
    tick();
    check("rst_edge_rd1", rd_data1, 32'h0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    rst = 1'b1;
    do_read(5'd3, 5'd0);
    check("rst_wr_lost_rd1", rd_data1, 32'h0);
    check("rst_wr_lost_rd2", rd_data2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
